// File: rtl/dcm_ps_responder.sv
`default_nettype none
// ============================================================================
// dcm_ps_responder : DCM variable phase-shift port responder (psen/psdone),
// saturating signed tap counter, reference and phase-shifted tick outputs.
// Optional macro DCM_PS_ERR_CHECK_EN builds the sticky protocol-error flag.
// Revision: 1.0 - initial release
// ============================================================================
module dcm_ps_responder #(
   parameter int PS_MAX      = 255,
   parameter int DONE_LAT    = 10,
   parameter int TICK_PERIOD = 16
) (
   input  logic       clkin,
   input  logic       rst,
   input  logic       psen,
   input  logic       psincdec,
   output logic       psdone,
   output logic       busy,
   output logic [9:0] phase_out,
   output logic       ps_overflow,
   output logic       ref_tick,
   output logic       shifted_tick,
   output logic       ps_err
);

   localparam int c_TW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
   localparam int c_LW = $clog2(DONE_LAT) + 1;
   localparam logic [c_LW-1:0]   c_LAT_LOAD = c_LW'(DONE_LAT - 1);
   localparam logic [c_LW-1:0]   c_LAT_LAST = c_LW'(1);
   localparam logic signed [9:0] c_PMAX     = 10'(PS_MAX);
   localparam logic signed [9:0] c_PMIN     = 10'(-PS_MAX);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_load;
   logic                  w_commit;
   logic                  w_sat;
   logic                  r_dir;
   logic [c_LW-1:0]       r_lat_cnt;
   logic                  r_psdone;
   logic                  r_busy;
   logic signed [9:0]     r_phase;
   logic                  r_ovf;
   logic [c_TW-1:0]       r_tick_cnt;
   logic                  r_ref_tick;
   logic                  r_shifted_tick;

   // A request is never accepted in the psdone cycle, even though the FSM is already idle.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (psen && !r_psdone) begin
               w_state_nxt = ST_WAIT;
               w_load      = 1'b1;
            end
         end
         ST_WAIT: begin
            if (r_lat_cnt == c_LAT_LAST) begin
               w_state_nxt = ST_IDLE;
               w_commit    = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign w_sat = r_dir ? (r_phase == c_PMAX) : (r_phase == c_PMIN);

   always_ff @(posedge clkin) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clkin) begin
      if (rst) begin
         r_dir     <= 1'b0;
         r_lat_cnt <= '0;
         r_psdone  <= 1'b0;
         r_busy    <= 1'b0;
         r_phase   <= '0;
         r_ovf     <= 1'b0;
      end else begin
         r_psdone <= w_commit;
         if (w_load) begin
            r_dir     <= psincdec;
            r_lat_cnt <= c_LAT_LOAD;
            r_busy    <= 1'b1;
         end else if (r_state == ST_WAIT) begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
         end
         if (w_commit) begin
            r_busy <= 1'b0;
            r_ovf  <= w_sat;
            if (!w_sat) r_phase <= r_dir ? (r_phase + 10'sd1) : (r_phase - 10'sd1);
         end
      end
   end

   // Low phase bits give the modulo-TICK_PERIOD match, so negative phases wrap naturally.
   always_ff @(posedge clkin) begin
      if (rst) begin
         r_tick_cnt     <= '0;
         r_ref_tick     <= 1'b0;
         r_shifted_tick <= 1'b0;
      end else begin
         r_tick_cnt     <= r_tick_cnt + 1'b1;
         r_ref_tick     <= (r_tick_cnt == '0);
         r_shifted_tick <= (r_tick_cnt == r_phase[c_TW-1:0]);
      end
   end

`ifdef DCM_PS_ERR_CHECK_EN
   logic r_ps_err;
   always_ff @(posedge clkin) begin
      if (rst)                         r_ps_err <= 1'b0;
      else if (psen && (r_busy || r_psdone)) r_ps_err <= 1'b1;
   end
   assign ps_err = r_ps_err;
`else
   assign ps_err = 1'b0;
`endif

   assign psdone       = r_psdone;
   assign busy         = r_busy;
   assign phase_out    = r_phase;
   assign ps_overflow  = r_ovf;
   assign ref_tick     = r_ref_tick;
   assign shifted_tick = r_shifted_tick;

endmodule
`default_nettype wire

// File: tb/tb_dcm_ps_responder.sv
`default_nettype none
// ============================================================================
// tb_dcm_ps_responder : directed self-checking bench for dcm_ps_responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dcm_ps_responder;

   logic       clkin = 1'b0;
   logic       rst = 1'b1;
   logic       psen = 1'b0;
   logic       psincdec = 1'b0;
   logic       psdone;
   logic       busy;
   logic [9:0] phase_out;
   logic       ps_overflow;
   logic       ref_tick;
   logic       shifted_tick;
   logic       ps_err;

   int n_cmp = 0;
   int n_bad = 0;
   int n_done = 0;
   logic last_ovf = 1'b0;

   dcm_ps_responder #(
      .PS_MAX(255),
      .DONE_LAT(10),
      .TICK_PERIOD(16)
   ) u_dut (
      .clkin(clkin),
      .rst(rst),
      .psen(psen),
      .psincdec(psincdec),
      .psdone(psdone),
      .busy(busy),
      .phase_out(phase_out),
      .ps_overflow(ps_overflow),
      .ref_tick(ref_tick),
      .shifted_tick(shifted_tick),
      .ps_err(ps_err)
   );

   always #5 clkin = ~clkin;

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clkin);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   // One request; leaves the bench one cycle past the psdone cycle.
   task automatic do_req(input logic dir);
      int i;
      psen = 1'b1;
      psincdec = dir;
      step();
      psen = 1'b0;
      i = 0;
      while (!psdone && i < 20) begin
         step();
         i++;
      end
      if (!psdone) chk("req_timeout", 0, 1);
      else n_done++;
      last_ovf = ps_overflow;
      step();
   endtask

   task automatic meas_tick(input string tag, input int exp);
      int i;
      int d;
      i = 0;
      while (!ref_tick && i < 40) begin
         step();
         i++;
      end
      d = 0;
      while (!shifted_tick && d < 40) begin
         step();
         d++;
      end
      chk(tag, d, exp);
   endtask

   initial begin
      int pulses;
      int first_k;
      int exp_err;

      // Reset state, sampled while rst is held.
      step();
      step();
      chk("rst_psdone", psdone, 0);
      chk("rst_busy", busy, 0);
      chk("rst_phase", $signed(phase_out), 0);
      chk("rst_ovf", ps_overflow, 0);
      chk("rst_ref_tick", ref_tick, 0);
      chk("rst_shifted_tick", shifted_tick, 0);
      chk("rst_ps_err", ps_err, 0);
      rst = 1'b0;
      step();

      // Basic increment with exact latency.
      psen = 1'b1;
      psincdec = 1'b1;
      step();
      psen = 1'b0;
      psincdec = 1'b0;
      chk("inc_busy_at_T", busy, 1);
      pulses = 0;
      first_k = -1;
      for (int k = 1; k <= 14; k++) begin
         step();
         if (psdone) begin
            pulses++;
            if (first_k < 0) first_k = k;
         end
         if (k == 8) chk("inc_phase_before", $signed(phase_out), 0);
         if (k == 9) begin
            chk("inc_phase_at_done", $signed(phase_out), 1);
            chk("inc_busy_at_done", busy, 0);
            chk("inc_ovf_at_done", ps_overflow, 0);
         end
      end
      chk("inc_done_latency", first_k, 9);
      chk("inc_done_pulses", pulses, 1);

      // psen during WAIT and during the psdone cycle must be ignored.
      psen = 1'b1;
      psincdec = 1'b1;
      step();
      psincdec = 1'b0;
      psen = 1'b0;
      pulses = 0;
      for (int k = 1; k <= 22; k++) begin
         step();
         if (psdone) begin
            pulses++;
            psen = 1'b1;
         end else begin
            psen = (k == 3);
         end
      end
      psen = 1'b0;
      chk("busy_ign_pulses", pulses, 1);
      chk("busy_ign_phase", $signed(phase_out), 2);
      chk("busy_ign_idle", busy, 0);
`ifdef DCM_PS_ERR_CHECK_EN
      exp_err = 1;
`else
      exp_err = 0;
`endif
      chk("busy_ign_ps_err", ps_err, exp_err);

      // Reset in the middle of a request aborts it.
      psen = 1'b1;
      psincdec = 1'b1;
      step();
      psen = 1'b0;
      repeat (4) step();
      rst = 1'b1;
      step();
      chk("midrst_busy", busy, 0);
      chk("midrst_psdone", psdone, 0);
      chk("midrst_phase", $signed(phase_out), 0);
      chk("midrst_ps_err", ps_err, 0);
      rst = 1'b0;
      psen = 1'b1;
      psincdec = 1'b0;
      step();
      psen = 1'b0;
      chk("midrst_fresh_busy", busy, 1);
      pulses = 0;
      first_k = -1;
      for (int k = 1; k <= 15; k++) begin
         step();
         if (psdone) begin
            pulses++;
            if (first_k < 0) first_k = k;
         end
      end
      chk("midrst_fresh_latency", first_k, 9);
      chk("midrst_fresh_pulses", pulses, 1);
      chk("midrst_fresh_phase", $signed(phase_out), -1);

      // Tick alignment for phases -1, 0 and 3.
      meas_tick("tick_phase_m1", 15);
      do_req(1'b1);
      meas_tick("tick_phase_0", 0);
      repeat (3) do_req(1'b1);
      chk("tick_phase3_value", $signed(phase_out), 3);
      meas_tick("tick_phase_3", 3);

      // Sweep to 40 then back to 5.
      do_reset();
      n_done = 0;
      repeat (40) do_req(1'b1);
      chk("sweep_up_done", n_done, 40);
      chk("sweep_up_phase", $signed(phase_out), 40);
      n_done = 0;
      repeat (35) do_req(1'b0);
      chk("sweep_dn_done", n_done, 35);
      chk("sweep_dn_phase", $signed(phase_out), 5);

      // Saturation at both limits.
      do_reset();
      n_done = 0;
      repeat (255) do_req(1'b1);
      chk("sat_hi_phase", $signed(phase_out), 255);
      chk("sat_hi_ovf_before", ps_overflow, 0);
      do_req(1'b1);
      chk("sat_hi_done", n_done, 256);
      chk("sat_hi_phase_held", $signed(phase_out), 255);
      chk("sat_hi_ovf", last_ovf, 1);
      do_req(1'b0);
      chk("sat_hi_dec_phase", $signed(phase_out), 254);
      chk("sat_hi_dec_ovf", last_ovf, 0);
      repeat (509) do_req(1'b0);
      chk("sat_lo_phase", $signed(phase_out), -255);
      chk("sat_lo_ovf_before", ps_overflow, 0);
      do_req(1'b0);
      chk("sat_lo_phase_held", $signed(phase_out), -255);
      chk("sat_lo_ovf", last_ovf, 1);
      do_req(1'b1);
      chk("sat_lo_inc_phase", $signed(phase_out), -254);
      chk("sat_lo_inc_ovf", last_ovf, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
